// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU data port, the host load/dump port and the data memory.
// The arbiter takes the slave modport; the surrounding system drives the master side.
interface dmem_arbiter_if #(
  parameter int AW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [31:0]   cpu_rdata;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [31:0]   host_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// CPU-priority arbiter for the single-port data memory with a bounded host starvation window.
// Define DMEM_ARB_STATS_EN to build the stall/beat statistics counters (tied to 0 otherwise).
module dmem_arbiter #(
  parameter int AW        = 16,
  parameter int MAX_WAIT  = 8,
  parameter int BURST_LEN = 4
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus,
  output logic [31:0]   stat_cpu_stalls,
  output logic [31:0]   stat_host_beats
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [WCW-1:0] WAIT_MAX   = WCW'(MAX_WAIT);
  localparam logic [WCW-1:0] WAIT_ONE   = WCW'(1);
  localparam logic [WCW-1:0] WAIT_ZERO  = WCW'(0);
  localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST_LEN - 1);
  localparam logic [BCW-1:0] BURST_ONE  = BCW'(1);
  localparam logic [BCW-1:0] BURST_ZERO = BCW'(0);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  logic [WCW-1:0] wait_cnt_r;
  logic [BCW-1:0] burst_cnt_r;
  owner_e         rd_owner_r;
  logic [31:0]    cpu_hold_r;
  logic [31:0]    host_hold_r;

  logic           host_gnt_s;
  logic           cpu_gnt_s;
  logic           cpu_stall_s;
  logic           mem_en_s;
  logic           mem_we_s;
  logic [AW-1:0]  mem_addr_s;
  logic [31:0]    mem_wdata_s;
  logic           cpu_rvalid_s;
  logic           host_rvalid_s;
  logic [31:0]    cpu_rdata_s;
  logic [31:0]    host_rdata_s;

  // Grant decision: host only wins when the CPU is idle, the host has starved, or a burst is open.
  always_comb begin
    host_gnt_s  = 1'b0;
    cpu_gnt_s   = 1'b0;
    cpu_stall_s = 1'b0;
    if (reset) begin
      host_gnt_s  = 1'b0;
      cpu_gnt_s   = 1'b0;
      cpu_stall_s = 1'b0;
    end else begin
      host_gnt_s  = bus.host_req &&
                    (!bus.cpu_req || (wait_cnt_r == WAIT_MAX) || (burst_cnt_r != BURST_ZERO));
      cpu_gnt_s   = bus.cpu_req && !host_gnt_s;
      cpu_stall_s = bus.cpu_req && !cpu_gnt_s;
    end
  end

  // Memory port mux, idle value is all-zero.
  always_comb begin
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = {AW{1'b0}};
    mem_wdata_s = 32'd0;
    if (host_gnt_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = bus.host_we;
      mem_addr_s  = bus.host_addr;
      mem_wdata_s = bus.host_wdata;
    end else if (cpu_gnt_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = bus.cpu_we;
      mem_addr_s  = bus.cpu_addr;
      mem_wdata_s = bus.cpu_wdata;
    end else begin
      mem_en_s    = 1'b0;
    end
  end

  // Starvation counter, burst counter and read-return owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_r  <= WAIT_ZERO;
      burst_cnt_r <= BURST_ZERO;
      rd_owner_r  <= OWN_NONE;
    end else begin
      if (!bus.host_req || host_gnt_s) begin
        wait_cnt_r <= WAIT_ZERO;
      end else if (wait_cnt_r != WAIT_MAX) begin
        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end

      // Wrapping on the last beat also keeps the counter at 0 when BURST_LEN is 1.
      if (!bus.host_req || (host_gnt_s && (burst_cnt_r == BURST_LAST))) begin
        burst_cnt_r <= BURST_ZERO;
      end else if (host_gnt_s) begin
        burst_cnt_r <= burst_cnt_r + BURST_ONE;
      end else begin
        burst_cnt_r <= burst_cnt_r;
      end

      if (host_gnt_s && !bus.host_we) begin
        rd_owner_r <= OWN_HOST;
      end else if (cpu_gnt_s && !bus.cpu_we) begin
        rd_owner_r <= OWN_CPU;
      end else begin
        rd_owner_r <= OWN_NONE;
      end
    end
  end

  // Capture returned read data so each port's rdata holds between its own reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_hold_r  <= 32'd0;
      host_hold_r <= 32'd0;
    end else begin
      case (rd_owner_r)
        OWN_CPU:  cpu_hold_r  <= bus.mem_rdata;
        OWN_HOST: host_hold_r <= bus.mem_rdata;
        default: begin
          cpu_hold_r  <= cpu_hold_r;
          host_hold_r <= host_hold_r;
        end
      endcase
    end
  end

  // Read return: memory data passes straight through in the cycle after the grant.
  always_comb begin
    cpu_rvalid_s  = 1'b0;
    host_rvalid_s = 1'b0;
    cpu_rdata_s   = cpu_hold_r;
    host_rdata_s  = host_hold_r;
    case (rd_owner_r)
      OWN_CPU: begin
        cpu_rvalid_s = 1'b1;
        cpu_rdata_s  = bus.mem_rdata;
      end
      OWN_HOST: begin
        host_rvalid_s = 1'b1;
        host_rdata_s  = bus.mem_rdata;
      end
      default: begin
        cpu_rvalid_s  = 1'b0;
        host_rvalid_s = 1'b0;
      end
    endcase
  end

  assign bus.host_gnt    = host_gnt_s;
  assign bus.cpu_stall   = cpu_stall_s;
  assign bus.mem_en      = mem_en_s;
  assign bus.mem_we      = mem_we_s;
  assign bus.mem_addr    = mem_addr_s;
  assign bus.mem_wdata   = mem_wdata_s;
  assign bus.cpu_rvalid  = cpu_rvalid_s;
  assign bus.cpu_rdata   = cpu_rdata_s;
  assign bus.host_rvalid = host_rvalid_s;
  assign bus.host_rdata  = host_rdata_s;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] beat_cnt_r;

  // Free-running wrap-around statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= 32'd0;
      beat_cnt_r  <= 32'd0;
    end else begin
      stall_cnt_r <= cpu_stall_s ? (stall_cnt_r + 32'd1) : stall_cnt_r;
      beat_cnt_r  <= host_gnt_s  ? (beat_cnt_r + 32'd1)  : beat_cnt_r;
    end
  end

  assign stat_cpu_stalls = stall_cnt_r;
  assign stat_host_beats = beat_cnt_r;
`else
  assign stat_cpu_stalls = 32'd0;
  assign stat_host_beats = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter with MAX_WAIT = 4, BURST_LEN = 4 and a 1-cycle memory.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] stat_cpu_stalls;
  logic [31:0] stat_host_beats;
  logic [31:0] ram [0:1023];

  int total = 0;
  int bad   = 0;
  int exp_stalls = 0;
  int exp_beats  = 0;

  typedef struct packed {
    logic        host;
    logic [31:0] data;
  } rd_exp_t;
  rd_exp_t sb[$];

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(16)) bus ();

  dmem_arbiter #(.AW(16), .MAX_WAIT(4), .BURST_LEN(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .stat_cpu_stalls (stat_cpu_stalls),
    .stat_host_beats (stat_host_beats)
  );

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr[9:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr[9:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [15:0] addr, input logic [31:0] wd);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
  endtask

  task automatic set_host(input logic req, input logic we, input logic [15:0] addr, input logic [31:0] wd);
    bus.host_req   = req;
    bus.host_we    = we;
    bus.host_addr  = addr;
    bus.host_wdata = wd;
  endtask

  task automatic chk_stats(input string tag);
`ifdef DMEM_ARB_STATS_EN
    chk({tag, ".stalls"}, stat_cpu_stalls, exp_stalls);
    chk({tag, ".beats"},  stat_host_beats, exp_beats);
`else
    chk({tag, ".stalls"}, stat_cpu_stalls, 32'd0);
    chk({tag, ".beats"},  stat_host_beats, 32'd0);
`endif
  endtask

  // One clock cycle: retire last cycle's reads, check this cycle's grant, queue new reads.
  task automatic cyc(input string tag, input logic exp_hgnt, input logic [31:0] exp_rd);
    rd_exp_t     e;
    logic        exp_cgnt, exp_cv, exp_hv;
    logic [31:0] exp_cd, exp_hd;
    @(negedge clk);
    exp_cv = 1'b0; exp_hv = 1'b0; exp_cd = 32'd0; exp_hd = 32'd0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.host) begin exp_hv = 1'b1; exp_hd = e.data; end
      else        begin exp_cv = 1'b1; exp_cd = e.data; end
    end
    chk({tag, ".cpu_rvalid"},  {31'd0, bus.cpu_rvalid},  {31'd0, exp_cv});
    chk({tag, ".host_rvalid"}, {31'd0, bus.host_rvalid}, {31'd0, exp_hv});
    if (exp_cv) chk({tag, ".cpu_rdata"},  bus.cpu_rdata,  exp_cd);
    if (exp_hv) chk({tag, ".host_rdata"}, bus.host_rdata, exp_hd);

    exp_cgnt = bus.cpu_req && !exp_hgnt;
    chk({tag, ".host_gnt"},  {31'd0, bus.host_gnt},  {31'd0, exp_hgnt});
    chk({tag, ".cpu_stall"}, {31'd0, bus.cpu_stall}, {31'd0, bus.cpu_req && exp_hgnt});
    chk({tag, ".mem_en"},    {31'd0, bus.mem_en},    {31'd0, exp_hgnt || exp_cgnt});
    if (exp_hgnt) begin
      chk({tag, ".mem_addr"}, {16'd0, bus.mem_addr}, {16'd0, bus.host_addr});
      chk({tag, ".mem_we"},   {31'd0, bus.mem_we},   {31'd0, bus.host_we});
      if (bus.host_we) chk({tag, ".mem_wdata"}, bus.mem_wdata, bus.host_wdata);
      else             sb.push_back('{host: 1'b1, data: exp_rd});
    end else if (exp_cgnt) begin
      chk({tag, ".mem_addr"}, {16'd0, bus.mem_addr}, {16'd0, bus.cpu_addr});
      chk({tag, ".mem_we"},   {31'd0, bus.mem_we},   {31'd0, bus.cpu_we});
      if (bus.cpu_we) chk({tag, ".mem_wdata"}, bus.mem_wdata, bus.cpu_wdata);
      else            sb.push_back('{host: 1'b0, data: exp_rd});
    end else begin
      chk({tag, ".mem_idle"}, {15'd0, bus.mem_we, bus.mem_addr}, 32'd0);
    end
    if (bus.cpu_req && exp_hgnt) exp_stalls++;
    if (exp_hgnt) exp_beats++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set_cpu(1'b0, 1'b0, 16'h0000, 32'd0);
    set_host(1'b0, 1'b0, 16'h0000, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.cpu_rvalid",  {31'd0, bus.cpu_rvalid},  32'd0);
    chk("rst.host_rvalid", {31'd0, bus.host_rvalid}, 32'd0);
    chk("rst.cpu_rdata",   bus.cpu_rdata,  32'd0);
    chk("rst.host_rdata",  bus.host_rdata, 32'd0);
    chk_stats("rst");
    set_cpu(1'b1, 1'b0, 16'h0010, 32'd0);
    set_host(1'b1, 1'b0, 16'h0011, 32'd0);
    #1;
    chk("rst.forced_host_gnt",  {31'd0, bus.host_gnt},  32'd0);
    chk("rst.forced_cpu_stall", {31'd0, bus.cpu_stall}, 32'd0);
    chk("rst.forced_mem_en",    {31'd0, bus.mem_en},    32'd0);
    set_cpu(1'b0, 1'b0, 16'h0000, 32'd0);
    set_host(1'b0, 1'b0, 16'h0000, 32'd0);
    reset = 1'b0;

    // CPU-only write then read-back
    set_cpu(1'b1, 1'b1, 16'h0064, 32'd7);
    cyc("cpu_wr", 1'b0, 32'd0);
    set_cpu(1'b1, 1'b0, 16'h0064, 32'd0);
    cyc("cpu_rd", 1'b0, 32'd7);
    set_cpu(1'b0, 1'b0, 16'h0000, 32'd0);
    cyc("cpu_rv", 1'b0, 32'd0);

    // Host-only burst of 6 writes, then read them back
    for (int i = 0; i < 6; i++) begin
      set_host(1'b1, 1'b1, 16'h0100 + 16'(i), 32'h0000_1000 + 32'(i));
      cyc("host_wr", 1'b1, 32'd0);
    end
    for (int i = 0; i < 6; i++) begin
      set_host(1'b1, 1'b0, 16'h0100 + 16'(i), 32'd0);
      cyc("host_rd", 1'b1, 32'h0000_1000 + 32'(i));
    end
    set_host(1'b0, 1'b0, 16'h0000, 32'd0);
    cyc("host_rd_tail", 1'b0, 32'd0);
    chk("cpu_rdata_hold", bus.cpu_rdata, 32'd7);

    // Continuous contention: 4 CPU cycles then 4 forced host beats, twice
    set_cpu(1'b1, 1'b1, 16'h0020, 32'h0000_00C0);
    set_host(1'b1, 1'b1, 16'h0030, 32'h0000_00B0);
    for (int k = 0; k < 16; k++) begin
      cyc("contend", (k % 8) >= 4, 32'd0);
    end

    // Host drops after 2 forced beats; on return the host must starve again
    for (int k = 0; k < 6; k++) begin
      cyc("drop_pre", k >= 4, 32'd0);
    end
    set_host(1'b0, 1'b0, 16'h0000, 32'd0);
    cyc("drop_cpu", 1'b0, 32'd0);
    set_host(1'b1, 1'b1, 16'h0030, 32'h0000_00B1);
    for (int k = 0; k < 5; k++) begin
      cyc("drop_rearm", k == 4, 32'd0);
    end
    set_cpu(1'b0, 1'b0, 16'h0000, 32'd0);
    set_host(1'b0, 1'b0, 16'h0000, 32'd0);
    cyc("idle", 1'b0, 32'd0);

    // Preload 0x10/0x11 (CPU wins the tie), then alternating reads
    set_cpu(1'b1, 1'b1, 16'h0010, 32'h0000_00A5);
    set_host(1'b1, 1'b1, 16'h0011, 32'h0000_005A);
    cyc("pre_tie", 1'b0, 32'd0);
    set_cpu(1'b0, 1'b0, 16'h0000, 32'd0);
    cyc("pre_host", 1'b1, 32'd0);
    set_host(1'b0, 1'b0, 16'h0000, 32'd0);
    set_cpu(1'b1, 1'b0, 16'h0010, 32'd0);
    cyc("alt_cpu", 1'b0, 32'h0000_00A5);
    set_cpu(1'b0, 1'b0, 16'h0000, 32'd0);
    set_host(1'b1, 1'b0, 16'h0011, 32'd0);
    cyc("alt_host", 1'b1, 32'h0000_005A);
    set_host(1'b0, 1'b0, 16'h0000, 32'd0);
    cyc("alt_tail", 1'b0, 32'd0);
    chk_stats("mid");

    // Reset in the middle of a forced host read burst with a read return pending
    set_cpu(1'b1, 1'b1, 16'h0020, 32'h0000_00C2);
    set_host(1'b1, 1'b0, 16'h0011, 32'd0);
    for (int k = 0; k < 5; k++) begin
      cyc("rst_burst", k == 4, 32'h0000_005A);
    end
    reset = 1'b1;
    sb.delete();
    exp_stalls = 0;
    exp_beats  = 0;
    #1;
    chk("rst_mid.mem_en",      {31'd0, bus.mem_en},      32'd0);
    chk("rst_mid.host_gnt",    {31'd0, bus.host_gnt},    32'd0);
    chk("rst_mid.cpu_stall",   {31'd0, bus.cpu_stall},   32'd0);
    chk("rst_mid.host_rvalid", {31'd0, bus.host_rvalid}, 32'd0);
    chk("rst_mid.cpu_rvalid",  {31'd0, bus.cpu_rvalid},  32'd0);
    chk("rst_mid.host_rdata",  bus.host_rdata, 32'd0);
    chk_stats("rst_mid");
    #2;
    reset = 1'b0;
    cyc("post_rst_cpu", 1'b0, 32'd0);
    cyc("post_rst_cpu2", 1'b0, 32'd0);
    set_cpu(1'b0, 1'b0, 16'h0000, 32'd0);
    set_host(1'b0, 1'b0, 16'h0000, 32'd0);
    cyc("end_idle", 1'b0, 32'd0);
    chk_stats("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port synchronous data memory between the CPU data port and the host port used to load and dump image buffers. The CPU has priority. A host that waits too long is forced in for a bounded burst, and the CPU is stalled while the host owns the memory. The block sits between the CPU datapath's data-memory interface and the data memory inside `top`.

## Interface
Parameters:
- `AW`, default 16: word-address width.
- `MAX_WAIT`, default 8: cycles a requesting host may be refused before it is forced in (≥1).
- `BURST_LEN`, default 4: maximum consecutive host beats per ownership (≥1).

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  CPU wants a memory access this cycle.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  AW  CPU word address.
- `cpu_wdata`  in  32  CPU write data.
- `cpu_stall`  out  1  CPU request refused this cycle; CPU holds its request.
- `cpu_rvalid`  out  1  `cpu_rdata` is valid (registered).
- `cpu_rdata`  out  32  read data for the CPU.
- `host_req`, `host_we`, `host_addr` [AW], `host_wdata` [32]: host equivalents of the CPU request inputs.
- `host_gnt`  out  1  host access accepted this cycle.
- `host_rvalid`  out  1  `host_rdata` is valid.
- `host_rdata`  out  32  read data for the host.
- `mem_en`, `mem_we`  out  1  memory enable and write enable.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data, valid one cycle after a read.
- `stat_cpu_stalls`, `stat_host_beats`  out  32  statistics counters (see Configuration).

## Operation
- State: `wait_cnt` (0..MAX_WAIT, saturating), `burst_cnt` (0..BURST_LEN-1), `rd_owner` (NONE/CPU/HOST).
- `in_burst` = (`burst_cnt` != 0).
- Per-cycle grant is combinational from the request inputs and registered state:
  - `host_gnt` = `host_req` && (!`cpu_req` || `wait_cnt` == MAX_WAIT || `in_burst`).
  - `cpu_gnt` = `cpu_req` && !`host_gnt`.
  - `cpu_stall` = `cpu_req` && !`cpu_gnt`.
- Memory mux: `mem_en` = `host_gnt` || `cpu_gnt`. `mem_we`, `mem_addr` and `mem_wdata` come from the granted port. When neither port is granted, these outputs are 0.
- `wait_cnt`:
  - cleared on `host_gnt` or when `host_req` is 0.
  - else incremented, saturating at MAX_WAIT.
- `burst_cnt`:
  - cleared if `host_req` is 0, or on the grant of beat BURST_LEN.
  - else incremented on each `host_gnt`.
  - with BURST_LEN = 1 it is constant 0.
- Read return: on a granted read, `rd_owner` latches the port. In the following cycle, that port's `rvalid` = 1 and its `rdata` = `mem_rdata`. The other port's `rdata` holds its last value.
- Writes produce no response; a write is complete when it is granted.
- Reset mid-burst: the burst is aborted and any pending `rvalid` is dropped. The memory sees no enable while `reset` is high.

## Timing
- Grant and memory strobes are combinational, with 0-cycle arbitration latency. Read data arrives at a fixed latency of 1 cycle.
- Reset values:
  - `cpu_rvalid` = 0, `host_rvalid` = 0.
  - `cpu_rdata` = 0, `host_rdata` = 0.
  - all counters = 0, `rd_owner` = NONE.
  - `mem_en` = 0, `host_gnt` = 0, `cpu_stall` = 0; these are forced to 0 while `reset` is asserted.
- Simultaneous requests with `wait_cnt` < MAX_WAIT and not in a burst: the CPU wins.
- Worst-case CPU stall is BURST_LEN consecutive cycles. Worst-case host wait is MAX_WAIT cycles.
- Back-to-back reads from alternating owners are legal. Each `rvalid` follows its own grant by exactly 1 cycle.

## Configuration
- `DMEM_ARB_STATS_EN` defined:
  - `stat_cpu_stalls` increments on every cycle with `cpu_stall` = 1.
  - `stat_host_beats` increments on every `host_gnt`.
  - Both are 32-bit, wrap at 2^32, and are cleared by `reset`.
- Undefined: both ports are tied to constant 0 and no counter flops are synthesized. Arbitration behaviour is identical in both builds.

## Test plan
All scenarios use MAX_WAIT = 4 and BURST_LEN = 4.
- CPU-only traffic: write 7 to 0x64, then read 0x64 → write granted with no stall; next cycle read granted; 1 cycle later `cpu_rvalid` = 1 and `cpu_rdata` = 7.
- Host-only traffic: burst of 6 writes to 0x100..0x105 with `cpu_req` = 0 → `host_gnt` high for all 6 cycles; memory contents match.
- Contention: `cpu_req` and `host_req` held continuously → CPU granted for 4 cycles; then host granted for 4 beats with `cpu_stall` = 1; pattern repeats.
- Host drops mid-burst: `host_req` falls after 2 forced beats → `burst_cnt` clears and the CPU is granted on the next cycle.
- Alternating reads: CPU read 0x10 (= 0xA5), then host read 0x11 (= 0x5A) → `cpu_rvalid` and `host_rvalid` fire on consecutive cycles, each with the correct data.
- Reset asserted mid-burst → `mem_en`, `host_gnt` and both `rvalid` drop to 0 immediately. With `DMEM_ARB_STATS_EN` defined, both statistics counters read 0 after reset.
